// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM output scheduler: state encoding, default
// geometry, counter widths and the silence word used on FIFO underrun.
package tdm_pkg;

  localparam int unsigned DEF_SLOTS     = 8;
  localparam int unsigned DEF_SLOT_BITS = 32;
  localparam int unsigned SLOT_CNT_W    = $clog2(DEF_SLOTS);
  localparam int unsigned BIT_CNT_W     = $clog2(DEF_SLOT_BITS);

  localparam logic [DEF_SLOT_BITS-1:0] SILENCE_WORD = '0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ARM  = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t STOP = 2'd3;

  // Counter width that stays legal for a count range of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_clkgen.sv
// Bit-clock divider: sclk toggles every div+1 enabled cycles; rise/fall
// strobes are high in the cycle before the corresponding sclk transition.
module tdm_clkgen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             rise_tick,
  output logic             fall_tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic             half_tick;

  assign half_tick = en && !load && (cnt == div_q);
  assign rise_tick = half_tick && !sclk;
  assign fall_tick = half_tick && sclk;

  // load restarts the divider with sclk low, so the first event is a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
      sclk  <= 1'b0;
    end else if (load) begin
      div_q <= div;
      cnt   <= '0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      sclk  <= 1'b0;
    end else if (half_tick) begin
      cnt   <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_ctrl.sv
// TDM frame scheduler/serialiser: fetches one FIFO word per slot, shifts it
// out MSB first with DSP-style frame sync, substituting silence on underrun.
module tdm_ctrl
  import tdm_pkg::*;
#(
  parameter int unsigned SLOTS     = DEF_SLOTS,
  parameter int unsigned SLOT_BITS = DEF_SLOT_BITS,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     ien,
  input  logic [DIV_W-1:0]         idiv,
  input  logic                     iclr_underrun,
  input  logic [SLOT_BITS-1:0]     ififo_data,
  input  logic                     ififo_empty,
  output logic                     ofifo_rd,
  output logic                     osclk,
  output logic                     ofs,
  output logic                     odata,
  output logic [$clog2(SLOTS)-1:0] oslot,
  output logic                     obusy,
  output logic                     ounderrun
);

  localparam int unsigned SW = cnt_width(SLOTS);
  localparam int unsigned BW = cnt_width(SLOT_BITS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] PRE_BIT   = BW'(SLOT_BITS - 2);

  state_t               state;
  logic [BW-1:0]        bit_cnt;
  logic [SW-1:0]        slot_cnt;
  logic                 in_frame;
  logic [SLOT_BITS-1:0] shreg;
  logic [SLOT_BITS-1:0] prefetch;
  logic [SLOT_BITS-1:0] load_word;
  logic                 rd_d;
  logic                 ur_pending;

  logic clk_en;
  logic arm_go;
  logic fall_tick;
  logic rise_unused;
  logic boundary;
  logic pre_last;
  logic stop_req;
  logic fetch;
  logic starve;
  logic ur_set;
  logic stop_done;

  tdm_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clk       (iclk),
    .rst_n     (irst),
    .en        (clk_en),
    .load      (arm_go),
    .div       (idiv),
    .sclk      (osclk),
    .rise_tick (rise_unused),
    .fall_tick (fall_tick)
  );

  always_comb begin
    clk_en    = (state == RUN) || (state == STOP);
    arm_go    = (state == ARM) && ien && !ififo_empty;
    boundary  = (state == RUN) && fall_tick && (!in_frame || bit_cnt == LAST_BIT);
    pre_last  = (state == RUN) && fall_tick && in_frame && (bit_cnt == PRE_BIT);
    stop_req  = pre_last && (slot_cnt == LAST_SLOT) && !ien;
    fetch     = pre_last && !stop_req && !ififo_empty;
    starve    = pre_last && !stop_req && ififo_empty;
    ur_set    = boundary && ur_pending;
    stop_done = (state == STOP) && fall_tick;
    // At the shortest bit period the read data lands on the same edge as the
    // slot load, so bypass the prefetch register in that cycle.
    load_word = rd_d ? ififo_data : prefetch;
  end

  assign oslot = slot_cnt;
  assign obusy = (state != IDLE);

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (ien) state <= ARM;
        ARM:     if (!ien) state <= IDLE;
                 else if (!ififo_empty) state <= RUN;
        RUN:     if (stop_req) state <= STOP;
        STOP:    if (fall_tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      ofifo_rd   <= 1'b0;
      rd_d       <= 1'b0;
      prefetch   <= '0;
      ur_pending <= 1'b0;
    end else begin
      ofifo_rd <= arm_go || fetch;
      rd_d     <= ofifo_rd;
      if (stop_done) begin
        prefetch   <= '0;
        ur_pending <= 1'b0;
      end else begin
        if (rd_d)        prefetch <= ififo_data;
        else if (starve) prefetch <= SLOT_BITS'(SILENCE_WORD);
        if (starve)      ur_pending <= 1'b1;
        else if (ur_set) ur_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      bit_cnt  <= '0;
      slot_cnt <= '0;
      in_frame <= 1'b0;
      shreg    <= '0;
      odata    <= 1'b0;
      ofs      <= 1'b0;
    end else if (stop_done) begin
      bit_cnt  <= '0;
      slot_cnt <= '0;
      in_frame <= 1'b0;
      shreg    <= '0;
      odata    <= 1'b0;
      ofs      <= 1'b0;
    end else if (boundary) begin
      bit_cnt  <= '0;
      slot_cnt <= (!in_frame || slot_cnt == LAST_SLOT) ? '0 : slot_cnt + 1'b1;
      ofs      <= !in_frame || (slot_cnt == LAST_SLOT);
      in_frame <= 1'b1;
      odata    <= load_word[SLOT_BITS-1];
      shreg    <= {load_word[SLOT_BITS-2:0], 1'b0};
    end else if ((state == RUN) && fall_tick) begin
      bit_cnt  <= bit_cnt + 1'b1;
      ofs      <= 1'b0;
      odata    <= shreg[SLOT_BITS-1];
      shreg    <= {shreg[SLOT_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst)              ounderrun <= 1'b0;
    else if (ur_set)        ounderrun <= 1'b1;
    else if (iclr_underrun) ounderrun <= 1'b0;
  end

endmodule

// File: tb/tb_tdm_ctrl.sv
// Directed bench for tdm_ctrl: FIFO model, serial receiver and per-scenario tasks.
module tb_tdm_ctrl;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        ien = 1'b0;
  logic [15:0] idiv = 16'd1;
  logic        iclr_underrun = 1'b0;
  logic [31:0] ififo_data = '0;
  logic        ififo_empty = 1'b1;
  logic        ofifo_rd, osclk, ofs, odata, obusy, ounderrun;
  logic [2:0]  oslot;

  int checks = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] rx_q[$];
  int rd_cnt, rd_err, fs_pulses, fs_len, fs_len_bad, fs_err, sclk_rises, pos;
  bit synced;
  logic [31:0] sh;

  tdm_ctrl #(.SLOTS(8), .SLOT_BITS(32), .DIV_W(16)) dut (
    .iclk(iclk), .irst(irst), .ien(ien), .idiv(idiv),
    .iclr_underrun(iclr_underrun), .ififo_data(ififo_data),
    .ififo_empty(ififo_empty), .ofifo_rd(ofifo_rd), .osclk(osclk),
    .ofs(ofs), .odata(odata), .oslot(oslot), .obusy(obusy),
    .ounderrun(ounderrun)
  );

  always #5 iclk = ~iclk;

  // FIFO read side and frame-sync width measurement
  always @(negedge iclk) begin
    if (ofifo_rd) begin
      rd_cnt++;
      if (fifo_q.size() == 0) rd_err++;
      else ififo_data = fifo_q.pop_front();
      ififo_empty = (fifo_q.size() == 0);
    end
    if (ofs) fs_len++;
    else if (fs_len > 0) begin
      fs_pulses++;
      if (fs_len != 2 * (int'(idiv) + 1)) fs_len_bad++;
      fs_len = 0;
    end
  end

  // Serial receiver sampling on the bit-clock rising edge
  always @(posedge osclk) begin
    sclk_rises++;
    if (ofs && !synced) begin
      synced = 1'b1;
      pos = 0;
    end
    if (synced) begin
      if (ofs !== (pos == 0)) fs_err++;
      sh = {sh[30:0], odata};
      if (pos % 32 == 31) rx_q.push_back(sh);
      pos = (pos + 1) % 256;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rx_q.delete();
    synced = 1'b0; pos = 0; sh = '0;
    rd_cnt = 0; rd_err = 0; fs_pulses = 0; fs_len = 0;
    fs_len_bad = 0; fs_err = 0; sclk_rises = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    ififo_empty = 1'b0;
  endtask

  task automatic do_reset();
    irst = 1'b0; ien = 1'b0; iclr_underrun = 1'b0;
    fifo_q.delete(); ififo_empty = 1'b1; ififo_data = '0;
    repeat (3) @(negedge iclk);
    #1;
    clear_mon();
    irst = 1'b1;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge iclk);
      if (!obusy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_slot(input int s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge iclk);
      if (obusy && int'(oslot) == s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rx(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge iclk);
      if (rx_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1 irst = 1'b0;
    repeat (2) @(negedge iclk);
    checks++; if (osclk !== 1'b0) begin failures++; $display("FAIL reset_osclk got %b want 0", osclk); end
    checks++; if (ofs !== 1'b0) begin failures++; $display("FAIL reset_ofs got %b want 0", ofs); end
    checks++; if (odata !== 1'b0) begin failures++; $display("FAIL reset_odata got %b want 0", odata); end
    checks++; if (ofifo_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got %b want 0", ofifo_rd); end
    checks++; if (oslot !== 3'd0) begin failures++; $display("FAIL reset_oslot got %0d want 0", oslot); end
    checks++; if (obusy !== 1'b0) begin failures++; $display("FAIL reset_obusy got %b want 0", obusy); end
    checks++; if (ounderrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got %b want 0", ounderrun); end
    do_reset();
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    idiv = 16'd1;
    for (int n = 0; n < 16; n++) push_word(32'h8000_0001 + 32'(n));
    ien = 1'b1;
    wait_rx(10, 3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_rx_timeout got %0d words want 10", rx_q.size()); end
    ien = 1'b0;
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_idle_timeout obusy=%b want 0", obusy); end
    checks++; if (rx_q.size() != 16) begin failures++; $display("FAIL basic_rx_count got %0d want 16", rx_q.size()); end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 32'h8000_0001 + 32'(i)) begin
        failures++; $display("FAIL basic_word%0d got %h want %h", i, rx_q[i], 32'h8000_0001 + 32'(i));
      end
    end
    checks++; if (rd_cnt != 16) begin failures++; $display("FAIL basic_reads got %0d want 16", rd_cnt); end
    checks++; if (fs_pulses != 2) begin failures++; $display("FAIL basic_fs_pulses got %0d want 2", fs_pulses); end
    checks++; if (fs_len_bad != 0) begin failures++; $display("FAIL basic_fs_width bad=%0d want 0", fs_len_bad); end
    checks++; if (fs_err != 0) begin failures++; $display("FAIL basic_fs_align err=%0d want 0", fs_err); end
    checks++; if (rd_err != 0) begin failures++; $display("FAIL basic_rd_empty err=%0d want 0", rd_err); end
    checks++; if (ounderrun !== 1'b0) begin failures++; $display("FAIL basic_underrun got %b want 0", ounderrun); end
    checks++; if ({osclk, ofs, odata} !== 3'b000) begin failures++; $display("FAIL basic_idle_pins got %b want 000", {osclk, ofs, odata}); end
  endtask

  task automatic test_underrun();
    bit ok;
    logic [31:0] exp_w[8];
    do_reset();
    idiv = 16'd1;
    for (int n = 0; n < 3; n++) push_word(32'h1111_0000 + 32'(n));
    exp_w = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h0,
              32'h0, 32'hA5A5_0001, 32'h0, 32'h0};
    ien = 1'b1;
    wait_slot(2, 2000, ok);
    checks++; if (!ok || ounderrun !== 1'b0) begin failures++; $display("FAIL ur_slot2 got %b want 0 (reached=%b)", ounderrun, ok); end
    wait_slot(3, 400, ok);
    checks++; if (!ok || ounderrun !== 1'b1) begin failures++; $display("FAIL ur_slot3 got %b want 1 (reached=%b)", ounderrun, ok); end
    wait_slot(4, 400, ok);
    #1 push_word(32'hA5A5_0001);
    ien = 1'b0;
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ur_idle_timeout obusy=%b want 0", obusy); end
    checks++; if (rx_q.size() != 8) begin failures++; $display("FAIL ur_rx_count got %0d want 8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_w[i]) begin failures++; $display("FAIL ur_word%0d got %h want %h", i, rx_q[i], exp_w[i]); end
    end
    checks++; if (rd_cnt != 4) begin failures++; $display("FAIL ur_reads got %0d want 4", rd_cnt); end
    checks++; if (fs_err != 0) begin failures++; $display("FAIL ur_fs_align err=%0d want 0", fs_err); end
    checks++; if (rd_err != 0) begin failures++; $display("FAIL ur_rd_empty err=%0d want 0", rd_err); end
    checks++; if (ounderrun !== 1'b1) begin failures++; $display("FAIL ur_sticky got %b want 1", ounderrun); end
  endtask

  task automatic test_flag_precedence();
    bit ok;
    do_reset();
    idiv = 16'd1;
    push_word(32'hDEAD_BEEF);
    ien = 1'b1;
    wait_slot(1, 2000, ok);
    checks++; if (!ok || ounderrun !== 1'b1) begin failures++; $display("FAIL flag_first_set got %b want 1 (reached=%b)", ounderrun, ok); end
    iclr_underrun = 1'b1;
    @(negedge iclk);
    iclr_underrun = 1'b0;
    checks++; if (ounderrun !== 1'b0) begin failures++; $display("FAIL flag_clear got %b want 0", ounderrun); end
    repeat (126) @(negedge iclk);
    iclr_underrun = 1'b1;
    @(negedge iclk);
    iclr_underrun = 1'b0;
    checks++; if (oslot !== 3'd2) begin failures++; $display("FAIL flag_coincide_slot got %0d want 2", oslot); end
    checks++; if (ounderrun !== 1'b1) begin failures++; $display("FAIL flag_set_wins got %b want 1", ounderrun); end
    iclr_underrun = 1'b1;
    @(negedge iclk);
    iclr_underrun = 1'b0;
    checks++; if (ounderrun !== 1'b0) begin failures++; $display("FAIL flag_later_clear got %b want 0", ounderrun); end
    ien = 1'b0;
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL flag_idle_timeout obusy=%b want 0", obusy); end
  endtask

  task automatic test_stop();
    bit ok;
    do_reset();
    idiv = 16'd1;
    for (int n = 0; n < 10; n++) push_word(32'h5A00_0000 + 32'(n));
    ien = 1'b1;
    wait_slot(2, 2000, ok);
    ien = 1'b0;
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stop_idle_timeout obusy=%b want 0", obusy); end
    checks++; if (rx_q.size() != 8) begin failures++; $display("FAIL stop_rx_count got %0d want 8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 32'h5A00_0000 + 32'(i)) begin failures++; $display("FAIL stop_word%0d got %h want %h", i, rx_q[i], 32'h5A00_0000 + 32'(i)); end
    end
    checks++; if (rd_cnt != 8) begin failures++; $display("FAIL stop_reads got %0d want 8", rd_cnt); end
    checks++; if (fifo_q.size() != 2) begin failures++; $display("FAIL stop_fifo_left got %0d want 2", fifo_q.size()); end
    checks++; if ({osclk, ofs, odata, obusy} !== 4'b0000) begin failures++; $display("FAIL stop_pins got %b want 0000", {osclk, ofs, odata, obusy}); end
  endtask

  task automatic test_empty_start();
    bit ok;
    int lat;
    do_reset();
    idiv = 16'd1;
    ien = 1'b1;
    repeat (40) @(negedge iclk);
    checks++; if (obusy !== 1'b1) begin failures++; $display("FAIL empty_busy got %b want 1", obusy); end
    checks++; if (sclk_rises != 0 || osclk !== 1'b0) begin failures++; $display("FAIL empty_sclk_quiet rises=%0d want 0", sclk_rises); end
    checks++; if (rd_cnt != 0) begin failures++; $display("FAIL empty_reads got %0d want 0", rd_cnt); end
    #1 push_word(32'hC3C3_0F0F);
    lat = 99;
    for (int n = 1; n <= 7; n++) begin
      @(negedge iclk);
      if (ofs) begin lat = n; break; end
    end
    checks++; if (lat > 7) begin failures++; $display("FAIL empty_fs_latency got >7 cycles want <=7"); end
    ien = 1'b0;
    wait_rx(1, 400, ok);
    checks++; if (!ok || rx_q[0] !== 32'hC3C3_0F0F) begin failures++; $display("FAIL empty_first_word got %h want c3c30f0f", ok ? rx_q[0] : 32'h0); end
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL empty_idle_timeout obusy=%b want 0", obusy); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int wait_n;
    do_reset();
    idiv = 16'd1;
    for (int n = 0; n < 16; n++) push_word(32'h7700_0000 + 32'(n));
    ien = 1'b1;
    wait_slot(5, 2000, ok);
    repeat (10) @(negedge iclk);
    #2 irst = 1'b0;
    #1;
    checks++; if ({osclk, ofs, odata, ofifo_rd, obusy, ounderrun} !== 6'b0 || oslot !== 3'd0) begin
      failures++; $display("FAIL areset_outputs got %b slot %0d want 000000 slot 0", {osclk, ofs, odata, ofifo_rd, obusy, ounderrun}, oslot);
    end
    @(negedge iclk);
    #1;
    clear_mon();
    fifo_q.delete(); ififo_empty = 1'b1;
    for (int n = 0; n < 8; n++) push_word(32'h3C00_0000 + 32'(n));
    irst = 1'b1;
    wait_n = 0;
    while (!ofs && wait_n < 50) begin @(negedge iclk); wait_n++; end
    checks++; if (!ofs || oslot !== 3'd0) begin failures++; $display("FAIL areset_restart ofs=%b slot=%0d want 1 slot 0", ofs, oslot); end
    wait_rx(2, 400, ok);
    ien = 1'b0;
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL areset_idle_timeout obusy=%b want 0", obusy); end
    checks++; if (rx_q.size() != 8) begin failures++; $display("FAIL areset_rx_count got %0d want 8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 32'h3C00_0000 + 32'(i)) begin failures++; $display("FAIL areset_word%0d got %h want %h", i, rx_q[i], 32'h3C00_0000 + 32'(i)); end
    end
    checks++; if (fs_err != 0) begin failures++; $display("FAIL areset_fs_align err=%0d want 0", fs_err); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_underrun();
    test_flag_precedence();
    test_stop();
    test_empty_start();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_ctrl.md
Name: tdm_ctrl

Overview:
- TDM frame scheduler and serialiser for the audio output path. Sits between the 1024x32 sample FIFO and the serial TDM pin.
- Generates the bit clock and frame sync, and fetches one 32-bit word per slot from the FIFO. Shifts each word out MSB first.
- On FIFO underrun it substitutes silence and records the event.
- Start/stop is frame-aligned, so a frame is never truncated.

Parameters:
SLOTS, 8, slots per frame (2..16)
SLOT_BITS, 32, bits per slot (equals FIFO word width)
DIV_W, 16, width of the bit-clock divider input

Ports:
iclk  in  1  system clock
irst  in  1  asynchronous reset, active-low
ien  in  1  run request; sampled only at frame boundaries
idiv  in  DIV_W  half-period of the bit clock, in iclk cycles, minus 1
iclr_underrun  in  1  single-cycle pulse; clears ounderrun
ififo_data  in  32  FIFO read data, valid the cycle after ofifo_rd
ififo_empty  in  1  FIFO empty flag
ofifo_rd  out  1  single-cycle FIFO read strobe
osclk  out  1  TDM bit clock
ofs  out  1  frame sync
odata  out  1  serial data
oslot  out  $clog2(SLOTS)  index of the slot currently shifting
obusy  out  1  high in any state other than IDLE
ounderrun  out  1  sticky underrun flag

Behaviour:
- Reset (irst=0, asynchronous): state=IDLE. osclk=0, ofs=0, odata=0, ofifo_rd=0, oslot=0, obusy=0, ounderrun=0. Shifter, prefetch register, counters and divider all clear.
- Divider: counts 0..idiv, then emits a half-tick and toggles osclk.
  - Bit period = 2*(idiv+1) iclk cycles; idiv=0 gives a period of 2 cycles.
  - idiv is latched at the ARM→RUN transition and stays constant for the whole run.
- Edge rules:
  - odata and ofs change only on the osclk falling half-tick.
  - The receiver samples on osclk rising.
- Counters:
  - The bit counter runs 0..SLOT_BITS-1; the slot counter runs 0..SLOTS-1.
  - Both wrap to 0 together at the end of a frame.
- ofs is high for exactly bit 0 of slot 0 (one bit period, DSP-style), and low otherwise.
- FSM:
  - IDLE: osclk held 0, odata 0. If ien=1, go to ARM.
  - ARM: wait until ififo_empty=0, then pulse ofifo_rd.
    - Capture ififo_data into the prefetch register on the next cycle.
    - Go to RUN; bit 0 of slot 0 starts on the next falling half-tick.
    - If ien drops while in ARM, return to IDLE.
  - RUN: at every slot boundary (falling edge that starts bit 0), load prefetch into the shifter and set oslot accordingly.
    - At the falling edge that starts bit SLOT_BITS-1 of each slot, check ififo_empty.
    - Not empty: pulse ofifo_rd for 1 cycle and capture ififo_data into prefetch on the following cycle.
    - Empty: no read; prefetch is loaded with 0 and the underrun marker is set.
  - RUN → STOP: at the last bit of slot SLOTS-1, if ien=0, go to STOP and issue no FIFO read.
  - STOP: finish that final bit period. Then drive osclk=0, ofs=0, odata=0 and go to IDLE.
- Underrun:
  - The substituted slot transmits 32 zero bits.
  - ounderrun is set on the cycle the zero word is loaded into the shifter.
  - The stream stays aligned: slot order is preserved and the next word is used in the next slot.
- iclr_underrun and a new underrun in the same cycle: set wins.
- FIFO latency: exactly one read per transmitted non-zero slot. ofifo_rd never asserts while ififo_empty=1.
- Reset mid-frame: all outputs return to reset values immediately. No partial-word recovery is attempted.

Decomposition:
- Shared package tdm_pkg holds:
  - the FSM state typedef (IDLE, ARM, RUN, STOP);
  - localparams SLOT_CNT_W=$clog2(SLOTS) and BIT_CNT_W=$clog2(SLOT_BITS);
  - the zero/silence word constant.
- One natural sub-module: tdm_clkgen. It contains the divider and osclk generation, and outputs single-cycle rise_tick/fall_tick strobes.
- The FSM, counters, prefetch and shifter stay in tdm_ctrl.

Test Plan:
- Basic run: idiv=1 (bit period 4), SLOTS=8, FIFO preloaded with 16 words 0x80000001+n, ien=1.
  - Bench checks: 2 frames transmitted bit-exact MSB first.
  - ofs high for 4 cycles at each frame start; 16 ofifo_rd pulses; ounderrun=0.
- Underrun: preload only 3 words.
  - Slots 0-2 carry data; slots 3-7 carry 0x00000000.
  - ounderrun=1 from the slot-3 load.
  - Pushing a word mid-frame makes it appear in the next slot; frame alignment is unchanged.
- Frame-aligned stop: deassert ien during slot 2.
  - Transmission continues to the end of slot 7, then osclk/ofs/odata=0 and obusy=0.
  - Exactly 8 reads occur for that frame.
- Start with empty FIFO: ien=1 with ififo_empty=1.
  - FSM holds in ARM with osclk quiet.
  - Write one word: the first ofs appears within 2*(idiv+1)+3 cycles.
- Flag precedence: iclr_underrun pulse coincident with a new underrun leaves ounderrun=1; a clear in a later cycle gives 0.
- Async reset: pull irst low mid-slot 5 asynchronously.
  - All outputs are 0 within the same cycle.
  - After release with ien=1, a fresh ARM→RUN sequence starts at slot 0 with correct ofs.
